clk_div_bank: RTL and testbench
===============================

# clk_div_bank

Parametrised multi-channel programmable clock-enable generator for the tile's housekeeping logic. It replaces fixed divide-by-2/4/8/16 outputs with CH independent channels, each with a run-time programmable divisor and a per-channel output mode (square wave or one-cycle strobe). Downstream logic consumes `tick` as a clock enable; `clk_out` is for pin-level observation only and is never used as a clock inside the tile.

## Interface
Parameters:
- `CH`, 4: number of channels, 1..8.
- `CW`, 8: divisor and counter width in bits, 1..16.

Ports:
- `clk`  in  1  single clock for the block; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `en`  in  1  global run; when 0, all counters and outputs hold and `tick` is 0.
- `align`  in  1  synchronous phase-align; zeroes every counter and `clk_out`.
- `wr_en`  in  1  divisor write strobe, one cycle.
- `wr_ch`  in  3  target channel of a write.
- `wr_div`  in  CW  divisor value D written to channel `wr_ch`.
- `mode`  in  CH  per-channel mode: 0 = square (toggle), 1 = strobe.
- `clk_out`  out  CH  registered divided outputs.
- `tick`  out  CH  registered one-cycle pulse at each channel terminal count.

## Operation
- Per channel c: divisor register `D[c]` (CW bits), counter `cnt[c]` (CW bits).
- Counting event for channel c is a rising edge with `en`=1 (see Configuration for the cascade variant).
- On a counting event:
  - if `cnt[c]` != `D[c]`: `cnt[c]` increments.
  - if `cnt[c]` == `D[c]` (terminal): `cnt[c]` <= 0 and `tick[c]` <= 1.
  - At terminal, `clk_out[c]` toggles in mode 0 and is set to 1 in mode 1.
- On any edge without a terminal event: `tick[c]` <= 0. In mode 1, `clk_out[c]` <= 0; in mode 0 it holds.
- Period is D+1 counting events per tick. In mode 0, `clk_out` has period 2(D+1) at 50% duty. D=0 is legal and gives a tick on every event.
- Write: `wr_en`=1 with `wr_ch` < CH:
  - `D[wr_ch]` <= `wr_div`.
  - That channel's `cnt` and `clk_out` <= 0 and its `tick` <= 0 (restart).
  - A write with `wr_ch` >= CH is ignored entirely.
- `align`=1: all `cnt`, `clk_out` and `tick` <= 0. `D` registers are unaffected. A simultaneous write still updates `D`.
- Priority per channel, highest first: reset, `align`, write to this channel, counting. A write coinciding with a terminal count wins, and no tick is produced.
- Changing `mode[c]` mid-run takes effect at the next edge. `clk_out` is not forced, except that in mode 1 it clears on the next non-terminal edge.
- Reset (`rst_n`=0 at an edge): `cnt`=0, `clk_out`=0, `tick`=0, and `D[c]` = 2^c−1 truncated to CW bits. With the default 4 channels this reproduces the legacy ÷2/÷4/÷8/÷16 behaviour in mode 0.
- A reset asserted mid-period abandons the count; no partial tick is produced.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Latency from a terminal count to `tick`/`clk_out` is 1 clock.
- After reset release, with `en`=1, channel 0 (D=0):
  - `tick[0]`=1 on every cycle from the 1st edge.
  - `clk_out[0]` = 1,0,1,0… starting at the 1st edge.
- Channel 1 (D=1): first tick after edge 2; `clk_out[1]` rises after edge 2 and falls after edge 4.
- A write at edge k: the first tick on that channel follows edge k+D+1 (new D), provided `en`=1 throughout.
- `en` deassertion freezes state at the next edge. Resuming continues the count exactly where it stopped.

## Configuration
- `CLK_DIV_CASCADE_EN` defined:
  - Channel c>0 has a counting event only on edges where `en`=1 and the registered `tick[c-1]`=1. Channel 0 counts as normal. This builds a prescaler chain for long divisions.
  - Each stage adds 1 cycle of phase lag relative to the previous channel.
  - Reset divisors are D[0]=0 and D[c]=1 for c>0. This gives square-wave periods of 2, 4, 8, 16 cycles in mode 0.
  - A write or `align` on channel c does not reset channels above it.
- Not defined: every channel counts on every enabled edge independently, and reset divisors are 2^c−1.

## Test plan
- Reset defaults, CH=4, CW=8, all mode 0, `en`=1 for 40 cycles -> `clk_out` periods 2/4/8/16 cycles; `tick[3]` high once every 8 cycles.
- Write D=4 to channel 2 mid-period, mode 1 -> `clk_out[2]`=`tick[2]`, a one-cycle pulse every 5 cycles; the first pulse follows the 5th edge after the write.
- `en` low for 7 cycles mid-count on channel 1 -> outputs frozen, `tick`=0; the count resumes with no lost or extra events.
- `align` pulse while channels are at arbitrary phase -> all `clk_out`=0 next cycle; channels 0..3 then re-emit the reset-default sequence in phase.
- Write with `wr_ch`=5 (CH=4), and a write to channel 0 on its terminal edge -> the first changes no `D`; the second gives no tick that cycle and the new D takes effect.
- With `CLK_DIV_CASCADE_EN` and defaults -> `clk_out` periods 2/4/8/16, each channel lagging the previous by 1 cycle; writing D=2 to channel 1 -> channel 1 period 6, channel 2 period 12.

Source files
------------

// File: rtl/clk_div_bank.sv
// clk_div_bank: CH-channel programmable clock-enable generator.
//
// Each channel c has a divisor register D[c] and a counter. Counting events
// advance the counter, and when it equals D[c] the channel emits a one-cycle
// tick and either toggles clk_out (mode 0, square) or pulses it (mode 1,
// strobe). The tick period is D+1 counting events.
//
// Optional feature macro: CLK_DIV_CASCADE_EN
//   When defined, channel c>0 only counts on enabled edges where the
//   registered tick of channel c-1 is high. The channels then form a prescaler
//   chain, and the reset divisors become D[0]=0, D[c>0]=1.
//   When undefined, every channel counts on every enabled edge and the reset
//   divisors are 2^c-1.
//
// Priority per channel, highest first: reset, align, write to this channel,
// counting. All outputs come straight from registers.

module clk_div_bank #(
    parameter int CH = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          align,
    input  logic          wr_en,
    input  logic [2:0]    wr_ch,
    input  logic [CW-1:0] wr_div,
    input  logic [CH-1:0] mode,
    output logic [CH-1:0] clk_out,
    output logic [CH-1:0] tick
);

    // Reset divisor for channel c, truncated to CW bits.
    function automatic logic [CW-1:0] rst_div(input int c);
        logic [31:0] full;
`ifdef CLK_DIV_CASCADE_EN
        if (c == 0) begin
            full = 32'd0;
        end else begin
            full = 32'd1;
        end
`else
        full = (32'd1 << c) - 32'd1;
`endif
        return full[CW-1:0];
    endfunction

    // State registers.
    logic [CW-1:0] div_r [CH];
    logic [CW-1:0] cnt_r [CH];
    logic [CH-1:0] out_r;
    logic [CH-1:0] tick_r;

    // Next-state values and per-channel qualifiers.
    logic [CW-1:0] div_s [CH];
    logic [CW-1:0] cnt_s [CH];
    logic [CH-1:0] out_s;
    logic [CH-1:0] tick_s;
    logic [CH-1:0] evt_s;
    logic [CH-1:0] hit_s;
    logic [CH-1:0] term_s;

    // Decide which channels see a counting event on this edge.
    always_comb begin
        evt_s = '0;
`ifdef CLK_DIV_CASCADE_EN
        evt_s[0] = en;
        for (int c = 1; c < CH; c++) begin
            evt_s[c] = en & tick_r[c-1];
        end
`else
        evt_s = {CH{en}};
`endif
    end

    // Decode the write target and detect the terminal count per channel.
    always_comb begin
        hit_s  = '0;
        term_s = '0;
        for (int c = 0; c < CH; c++) begin
            hit_s[c]  = wr_en & (wr_ch == c[2:0]);
            term_s[c] = (cnt_r[c] == div_r[c]);
        end
    end

    // Per-channel next state following the align > write > count priority.
    always_comb begin
        out_s  = out_r;
        tick_s = '0;
        for (int c = 0; c < CH; c++) begin
            div_s[c] = div_r[c];
            cnt_s[c] = cnt_r[c];
            if (align) begin
                // Phase align: restart every channel, but a coincident
                // write still lands in the divisor register.
                cnt_s[c]  = '0;
                out_s[c]  = 1'b0;
                tick_s[c] = 1'b0;
                if (hit_s[c]) begin
                    div_s[c] = wr_div;
                end else begin
                    div_s[c] = div_r[c];
                end
            end else if (hit_s[c]) begin
                // Divisor write restarts the channel and suppresses any
                // terminal count falling on the same edge.
                div_s[c]  = wr_div;
                cnt_s[c]  = '0;
                out_s[c]  = 1'b0;
                tick_s[c] = 1'b0;
            end else if (evt_s[c]) begin
                if (term_s[c]) begin
                    cnt_s[c]  = '0;
                    tick_s[c] = 1'b1;
                    if (mode[c]) begin
                        out_s[c] = 1'b1;
                    end else begin
                        out_s[c] = ~out_r[c];
                    end
                end else begin
                    cnt_s[c]  = cnt_r[c] + CW'(1'b1);
                    tick_s[c] = 1'b0;
                    if (mode[c]) begin
                        out_s[c] = 1'b0;
                    end else begin
                        out_s[c] = out_r[c];
                    end
                end
            end else if (en) begin
                // Enabled edge with no event for this channel (only in the
                // cascade chain): strobe output drops, square output holds.
                tick_s[c] = 1'b0;
                if (mode[c]) begin
                    out_s[c] = 1'b0;
                end else begin
                    out_s[c] = out_r[c];
                end
            end else begin
                // Globally stopped: everything freezes, tick stays low.
                tick_s[c] = 1'b0;
                out_s[c]  = out_r[c];
            end
        end
    end

    // Register all channel state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                div_r[c] <= rst_div(c);
                cnt_r[c] <= '0;
            end
            out_r  <= '0;
            tick_r <= '0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                div_r[c] <= div_s[c];
                cnt_r[c] <= cnt_s[c];
            end
            out_r  <= out_s;
            tick_r <= tick_s;
        end
    end

    assign clk_out = out_r;
    assign tick    = tick_r;

endmodule

// File: tb/tb_clk_div_bank.sv
// Testbench for clk_div_bank (default build, CH=4, CW=8): a table of
// directed vectors from reset, two hand-written multi-cycle sequences, and
// a randomized run checked against an event-counting reference model.

module tb_clk_div_bank;

    localparam int CH = 4;
    localparam int CW = 8;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          align;
    logic          wr_en;
    logic [2:0]    wr_ch;
    logic [CW-1:0] wr_div;
    logic [CH-1:0] mode;
    logic [CH-1:0] clk_out;
    logic [CH-1:0] tick;

    int errors = 0;
    int checks = 0;

    clk_div_bank #(.CH(CH), .CW(CW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .align   (align),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
        .mode    (mode),
        .clk_out (clk_out),
        .tick    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: events since the last restart, divisor, outputs.
    int m_n   [CH];
    int m_d   [CH];
    bit m_out [CH];
    bit m_tick[CH];

    task automatic model_update();
        for (int c = 0; c < CH; c++) begin
            bit hit;
            hit = wr_en && (int'(wr_ch) == c);
            if (!rst_n) begin
                m_n[c] = 0; m_out[c] = 0; m_tick[c] = 0;
                m_d[c] = ((1 << c) - 1) % 256;
            end else if (align) begin
                m_n[c] = 0; m_out[c] = 0; m_tick[c] = 0;
                if (hit) m_d[c] = int'(wr_div);
            end else if (hit) begin
                m_d[c] = int'(wr_div);
                m_n[c] = 0; m_out[c] = 0; m_tick[c] = 0;
            end else if (en) begin
                m_n[c] = m_n[c] + 1;
                if (m_n[c] % (m_d[c] + 1) == 0) begin
                    m_tick[c] = 1;
                    m_out[c]  = mode[c] ? 1'b1 : !m_out[c];
                end else begin
                    m_tick[c] = 0;
                    if (mode[c]) m_out[c] = 0;
                end
            end else begin
                m_tick[c] = 0;
            end
        end
    endtask

    function automatic logic [CH-1:0] model_out();
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = m_out[c];
        return v;
    endfunction

    function automatic logic [CH-1:0] model_tick();
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = m_tick[c];
        return v;
    endfunction

    // One clock: inputs already driven; update model at the edge, then
    // move to the falling edge where outputs are sampled.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic a, input logic w,
                         input logic [2:0] ch, input logic [CW-1:0] d, input logic [CH-1:0] m);
        rst_n = r; en = e; align = a; wr_en = w; wr_ch = ch; wr_div = d; mode = m;
    endtask

    typedef struct {
        logic          rst_n;
        logic          en;
        logic          align;
        logic          wr_en;
        logic [2:0]    wr_ch;
        logic [CW-1:0] wr_div;
        logic [CH-1:0] mode;
        logic [CH-1:0] exp_out;
        logic [CH-1:0] exp_tick;
        string         name;
    } vec_t;

    vec_t vt[17];

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 4'b0000);

        // Directed vectors from reset: default divisors 0/1/3/7, mode 0.
        vt[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 4'b0000, 4'b0000, 4'b0000, "reset"};
        vt[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 4'b0000, 4'b0001, 4'b0001, "run"};
        vt[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 4'b0000, 4'b0010, 4'b0011, "run"};
        vt[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 4'b0000, 4'b0011, 4'b0001, "run"};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 4'b0000, 4'b0100, 4'b0111, "run"};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 4'b0000, 4'b0101, 4'b0001, "run"};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 4'b0000, 4'b0110, 4'b0011, "run"};
        vt[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 4'b0000, 4'b0111, 4'b0001, "run"};
        vt[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 4'b0000, 4'b1000, 4'b1111, "run"};
        vt[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 4'b0000, 4'b1000, 4'b0000, "hold"};
        vt[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 4'b0000, 4'b1001, 4'b0001, "resume"};
        vt[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 8'd2, 4'b0000, 4'b1010, 4'b0010, "wr_ch0"};
        vt[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 8'd9, 4'b0000, 4'b1010, 4'b0000, "wr_ch5"};
        vt[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 4'b0000, 4'b0000, 4'b0000, "align"};
        vt[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 4'b0000, 4'b0000, 4'b0000, "post_align"};
        vt[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 4'b0000, 4'b0010, 4'b0010, "post_align"};
        vt[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 4'b0000, 4'b0011, 4'b0001, "post_align"};

        for (int i = 0; i < 17; i++) begin
            drive(vt[i].rst_n, vt[i].en, vt[i].align, vt[i].wr_en,
                  vt[i].wr_ch, vt[i].wr_div, vt[i].mode);
            step();
            chk($sformatf("%s_out[%0d]", vt[i].name, i), 32'(clk_out), 32'(vt[i].exp_out));
            chk($sformatf("%s_tick[%0d]", vt[i].name, i), 32'(tick), 32'(vt[i].exp_tick));
        end

        // Write to channel 0 on its terminal edge (D=0 ticks every edge).
        drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 4'b0000);
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 4'b0000);
        step();
        step();
        chk("pre_wr_tick0", 32'(tick[0]), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 8'd3, 4'b0000);
        step();
        chk("wr_term_tick0", 32'(tick[0]), 32'd0);
        chk("wr_term_out0", 32'(clk_out[0]), 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 4'b0000);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("newd_tick0[%0d]", i), 32'(tick[0]), (i == 4) ? 32'd1 : 32'd0);
        end

        // Channel 2 strobe mode with D=4: pulses on the 5th and 10th edge.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 8'd4, 4'b0100);
        step();
        chk("strobe_wr_tick2", 32'(tick[2]), 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 4'b0100);
        for (int i = 1; i <= 10; i++) begin
            step();
            chk($sformatf("strobe_tick2[%0d]", i), 32'(tick[2]),
                (i == 5 || i == 10) ? 32'd1 : 32'd0);
            chk($sformatf("strobe_out2[%0d]", i), 32'(clk_out[2]),
                (i == 5 || i == 10) ? 32'd1 : 32'd0);
        end

        // Randomized run against the reference model.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 4'b0000);
        step();
        for (int i = 0; i < 2000; i++) begin
            rst_n  = ($urandom_range(0, 199) != 0);
            en     = ($urandom_range(0, 99) < 85);
            align  = ($urandom_range(0, 39) == 0);
            wr_en  = ($urandom_range(0, 11) == 0);
            wr_ch  = 3'($urandom_range(0, 7));
            wr_div = 8'($urandom_range(0, 12));
            if ($urandom_range(0, 29) == 0) mode = 4'($urandom);
            step();
            chk($sformatf("rnd_out[%0d]", i), 32'(clk_out), 32'(model_out()));
            chk($sformatf("rnd_tick[%0d]", i), 32'(tick), 32'(model_tick()));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
